// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one 4-bit ALU between NUM_REQ requesters.
// Optional macro ALU_DIVZERO_ERR_EN adds the rsp_err divide-by-zero flag.

module device (
    input  logic [3:0] in1_i,
    input  logic [3:0] in2_i,
    input  logic [1:0] opcode_i,
    output logic [7:0] out_o
);

    logic [7:0] a8;
    logic [7:0] b8;

    assign a8 = {4'b0000, in1_i};
    assign b8 = {4'b0000, in2_i};

    // Zero-extended arithmetic, result wraps mod 256; x/0 returns all ones
    always_comb begin
        out_o = '0;
        unique case (opcode_i)
            2'b00: out_o = a8 + b8;
            2'b01: out_o = a8 - b8;
            2'b10: out_o = a8 * b8;
            2'b11: begin
                if (in2_i == 4'd0) begin
                    out_o = 8'hFF;
                end else begin
                    out_o = {4'b0000, in1_i / in2_i};
                end
            end
            default: out_o = '0;
        endcase
    end

endmodule

module alu_req_scheduler #(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_in1,
    input  logic [4*NUM_REQ-1:0] req_in2,
    input  logic [2*NUM_REQ-1:0] req_opcode,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [1:0]           rsp_id
`ifdef ALU_DIVZERO_ERR_EN
    ,
    output logic                 rsp_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [1:0] id_q, id_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_id_q, rsp_id_d;
`ifdef ALU_DIVZERO_ERR_EN
    logic       rsp_err_q, rsp_err_d;
`endif

    logic       hi_found, lo_found, gnt_found;
    logic [1:0] hi_idx, lo_idx, gnt_idx;
    logic [3:0] sel_a, sel_b;
    logic [1:0] sel_op;
    logic [7:0] alu_out;

    device u_device (
        .in1_i    (a_q),
        .in2_i    (b_q),
        .opcode_i (op_q),
        .out_o    (alu_out)
    );

    // Round-robin pick: first valid at/above ptr, else first valid overall
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 2'(i);
            end
            if (req_valid[i] && !hi_found && (i >= int'(ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = 2'(i);
            end
        end
        gnt_found = hi_found | lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Mux the granted requester's operand lanes
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                sel_a  = req_in1[4*i +: 4];
                sel_b  = req_in2[4*i +: 4];
                sel_op = req_opcode[2*i +: 2];
            end
        end
    end

    // Next-state and handshake logic for IDLE -> EXEC -> RESP
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
`ifdef ALU_DIVZERO_ERR_EN
        rsp_err_d   = rsp_err_q;
`endif
        req_ready   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready = NUM_REQ'(1) << gnt_idx;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    op_d      = sel_op;
                    id_d      = gnt_idx;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef ALU_DIVZERO_ERR_EN
                rsp_err_d   = (op_q == 2'b11) && (b_q == 4'd0);
`endif
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (id_q == 2'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = id_q + 2'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointer, latched command and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
`ifdef ALU_DIVZERO_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
`ifdef ALU_DIVZERO_ERR_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
`ifdef ALU_DIVZERO_ERR_EN
    assign rsp_err   = rsp_err_q;
`endif

endmodule
